// File: rtl/mole_target_gen_if.sv
// Game-side bundle between the round sequencer and the rest of the switch-reaction game.
// The slave modport is the sequencer's view; master is the player/detector side.
interface mole_target_gen_if;
    logic       start;
    logic       hit;
    logic       miss;
    logic       freq;
    logic [7:0] random;
    logic [7:0] led;
    logic       round_active;
    logic [7:0] score;
    logic [7:0] misses;
    logic       game_over;

    modport slave (
        input  start, hit, miss,
        output freq, random, led, round_active, score, misses, game_over
    );

    modport master (
        output start, hit, miss,
        input  freq, random, led, round_active, score, misses, game_over
    );
endinterface

// File: rtl/mole_target_gen.sv
// Round sequencer for the switch-reaction game: lights a pseudo-random LED each round,
// strobes the hit detector, scores its verdicts and signals game over after ROUNDS rounds.
module mole_target_gen #(
    parameter int unsigned WINDOW_CYCLES = 100000000,
    parameter int unsigned GAP_CYCLES    = 25000000,
    parameter int unsigned ROUNDS        = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    mole_target_gen_if.slave bus
);
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_ARM    = 3'd2,
        S_ACTIVE = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q;
    logic [7:0]       lfsr_q;
    logic [2:0]       prev_idx_q;
    logic [7:0]       round_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             freq_q;
    logic [7:0]       random_q;
    logic [7:0]       led_q;
    logic             round_active_q;
    logic [7:0]       score_q;
    logic [7:0]       misses_q;
    logic             game_over_q;

    logic [7:0]       lfsr_d;
    logic [2:0]       idx_d;
    logic [7:0]       round_cnt_d;
    logic             win_done_s;
    logic             verdict_s;

    assign lfsr_d      = lfsr_step(lfsr_q);
    // Never repeat the previous LED: bump to the neighbour on a collision.
    assign idx_d       = (lfsr_q[2:0] == prev_idx_q) ? (lfsr_q[2:0] + 3'd1) : lfsr_q[2:0];
    assign round_cnt_d = round_cnt_q + 8'd1;
    assign win_done_s  = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));
    assign verdict_s   = bus.hit | bus.miss | win_done_s;

    // Round sequencer FSM with all game outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            lfsr_q         <= LFSR_SEED;
            prev_idx_q     <= 3'd0;
            round_cnt_q    <= 8'd0;
            gap_cnt_q      <= {GAP_W{1'b0}};
            win_cnt_q      <= {WIN_W{1'b0}};
            freq_q         <= 1'b0;
            random_q       <= 8'd0;
            led_q          <= 8'd0;
            round_active_q <= 1'b0;
            score_q        <= 8'd0;
            misses_q       <= 8'd0;
            game_over_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            freq_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        score_q     <= 8'd0;
                        misses_q    <= 8'd0;
                        round_cnt_q <= 8'd0;
                        game_over_q <= 1'b0;
                        gap_cnt_q   <= GAP_W'(GAP_CYCLES - 1);
                        state_q     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == {GAP_W{1'b0}}) begin
                        state_q <= S_ARM;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                S_ARM: begin
                    freq_q         <= 1'b1;
                    random_q       <= 8'd1 << idx_d;
                    led_q          <= 8'd1 << idx_d;
                    round_active_q <= 1'b1;
                    prev_idx_q     <= idx_d;
                    win_cnt_q      <= {WIN_W{1'b0}};
                    state_q        <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    // hit wins over miss; a timeout scores like a miss
                    if (bus.hit) begin
                        score_q <= sat_inc(score_q);
                    end else if (bus.miss || win_done_s) begin
                        misses_q <= sat_inc(misses_q);
                    end
                    if (verdict_s) begin
                        led_q          <= 8'd0;
                        round_active_q <= 1'b0;
                        state_q        <= S_RESULT;
                    end else begin
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                    end
                end
                S_RESULT: begin
                    round_cnt_q <= round_cnt_d;
                    if (round_cnt_d == 8'(ROUNDS)) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                        state_q   <= S_GAP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.freq         = freq_q;
    assign bus.random       = random_q;
    assign bus.led          = led_q;
    assign bus.round_active = round_active_q;
    assign bus.score        = score_q;
    assign bus.misses       = misses_q;
    assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_mole_target_gen.sv
// Self-checking bench for mole_target_gen: directed game scenarios followed by randomized
// games, checked against a round-level reference model of score, misses and LED targets.
module tb_mole_target_gen;
    localparam int W = 8;
    localparam int G = 4;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mole_target_gen_if bus_if ();

    mole_target_gen #(
        .WINDOW_CYCLES(W),
        .GAP_CYCLES   (G),
        .ROUNDS       (R),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    int m_score, m_miss, m_round;
    logic [2:0] m_prev;
    logic [7:0] m_random;

    // Clock edges since reset release; edge n leaves the LFSR n steps past the seed.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_score = 0;
        m_miss  = 0;
        m_round = 0;
    endtask

    // Wait for the round-start strobe, optionally poking hit during the gap, then check the target.
    task automatic wait_freq(input int lat, input logic poke_hit);
        int n;
        logic [7:0] s;
        logic [2:0] idx;
        logic [7:0] prev;
        n = 0;
        while (bus_if.freq !== 1'b1 && n < 40) begin
            if (poke_hit && n == 1) bus_if.hit = 1'b1;
            tick();
            bus_if.hit = 1'b0;
            n++;
        end
        check("freq_latency", n, lat);
        s   = lfsr_at(cyc - 1);
        idx = s[2:0];
        if (idx == m_prev) idx = idx + 3'd1;
        m_prev   = idx;
        prev     = m_random;
        m_random = 8'd1 << idx;
        check("random_onehot", {31'd0, $onehot(bus_if.random)}, 32'd1);
        check("random_no_repeat", {31'd0, (bus_if.random !== prev)}, 32'd1);
        check("random_value", bus_if.random, m_random);
        check("led_at_freq", bus_if.led, m_random);
        check("round_active_at_freq", bus_if.round_active, 1'b1);
    endtask

    // Play one ACTIVE window: verdict driven on ACTIVE cycle resp (0 = never respond).
    task automatic play_round(input int resp, input logic h, input logic m, input logic poke_start);
        logic verdict;
        verdict = 1'b0;
        for (int k = 1; k <= W && !verdict; k++) begin
            if (k == resp) begin
                bus_if.hit  = h;
                bus_if.miss = m;
                verdict     = h | m;
            end
            if (poke_start && k == 2) bus_if.start = 1'b1;
            tick();
            bus_if.hit   = 1'b0;
            bus_if.miss  = 1'b0;
            bus_if.start = 1'b0;
            if (k == 1) check("freq_one_cycle", bus_if.freq, 1'b0);
            if (!verdict && k < W) begin
                check("led_active", bus_if.led, m_random);
                check("round_active", bus_if.round_active, 1'b1);
            end
        end
        if (verdict && h) m_score++;
        else              m_miss++;
        m_round++;
        check("led_after_verdict", bus_if.led, 8'd0);
        check("round_inactive", bus_if.round_active, 1'b0);
        check("score", bus_if.score, m_score);
        check("misses", bus_if.misses, m_miss);
    endtask

    task automatic begin_game();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        model_clear();
        check("score_cleared", bus_if.score, 8'd0);
        check("misses_cleared", bus_if.misses, 8'd0);
        check("game_over_cleared", bus_if.game_over, 1'b0);
    endtask

    task automatic end_game(input int hold);
        tick();
        check("game_over", bus_if.game_over, 1'b1);
        check("rounds_played", m_round, R);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("done_freq", bus_if.freq, 1'b0);
            check("done_led", bus_if.led, 8'd0);
        end
        check("done_hold_flag", bus_if.game_over, 1'b1);
        check("done_hold_score", bus_if.score, m_score);
        check("done_hold_misses", bus_if.misses, m_miss);
        check("done_hold_random", bus_if.random, m_random);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.hit   = 1'b0;
        bus_if.miss  = 1'b0;
        m_prev       = 3'd0;
        m_random     = 8'd0;
        model_clear();
        repeat (2) tick();
        rst = 1'b0;

        // Idle after reset: nothing moves without start.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_freq", bus_if.freq, 1'b0);
        end
        check("idle_random", bus_if.random, 8'd0);
        check("idle_led", bus_if.led, 8'd0);
        check("idle_active", bus_if.round_active, 1'b0);
        check("idle_score", bus_if.score, 8'd0);
        check("idle_misses", bus_if.misses, 8'd0);
        check("idle_game_over", bus_if.game_over, 1'b0);

        // Game 1: hit on cycle 3, timeout, simultaneous hit+miss.
        begin_game();
        wait_freq(5, 1'b0);
        play_round(3, 1'b1, 1'b0, 1'b0);
        wait_freq(6, 1'b0);
        play_round(0, 1'b0, 1'b0, 1'b0);
        wait_freq(6, 1'b0);
        play_round(2, 1'b1, 1'b1, 1'b0);
        end_game(5);
        check("game1_score", bus_if.score, 8'd2);
        check("game1_misses", bus_if.misses, 8'd1);

        // Game 2: start during ACTIVE and hit during GAP are ignored; reset mid-round.
        begin_game();
        wait_freq(5, 1'b0);
        play_round(4, 1'b0, 1'b1, 1'b1);
        wait_freq(6, 1'b1);
        check("gap_hit_ignored", bus_if.score, m_score);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", bus_if.led, 8'd0);
        check("async_rst_score", bus_if.score, 8'd0);
        check("async_rst_misses", bus_if.misses, 8'd0);
        check("async_rst_active", bus_if.round_active, 1'b0);
        tick();
        rst      = 1'b0;
        m_prev   = 3'd0;
        m_random = 8'd0;
        model_clear();
        check("post_rst_random", bus_if.random, 8'd0);

        // Randomized games: responses and DONE dwell time vary, targets follow the LFSR.
        for (int g = 0; g < 85; g++) begin
            begin_game();
            for (int r = 0; r < R; r++) begin
                wait_freq((r == 0) ? 5 : 6, 1'b0);
                play_round($urandom_range(0, W), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'b0);
            end
            end_game($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
